shift_add_multiplier: RTL and testbench

//  Sequential unsigned multiplier, one partial product per cycle (radix-2 shift-and-add).

---
 rtl/mult_pkg.sv | 8 +
 rtl/carry_lookahead_adder.sv | 37 +++
 rtl/shift_add_multiplier.sv | 79 +++++++
 tb/tb_shift_add_multiplier.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// mult_pkg: shared FSM state type and counter-width helper for the shift-add multiplier
package mult_pkg;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction
endpackage

// File: rtl/carry_lookahead_adder.sv
// carry_lookahead_adder: WIDTH-bit adder with every carry formed directly from generate/propagate terms
module carry_lookahead_adder #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    logic [WIDTH:0]   c;

    // c[k] = g[k-1] | p[k-1]g[k-2] | ... | p[k-1..0]cin, flattened rather than rippled
    function automatic logic carry_into(input int k, input logic [WIDTH-1:0] gv, input logic [WIDTH-1:0] pv, input logic ci);
        logic r;
        logic pr;
        r  = 1'b0;
        pr = 1'b1;
        for (int j = k - 1; j >= 0; j--) begin
            r  = r | (pr & gv[j]);
            pr = pr & pv[j];
        end
        return r | (pr & ci);
    endfunction

    assign g = a & b;
    assign p = a ^ b;

    for (genvar i = 0; i <= WIDTH; i++) begin : g_carry
        assign c[i] = carry_into(i, g, p, cin);
    end

    assign sum  = p ^ c[WIDTH-1:0];
    assign cout = c[WIDTH];
endmodule

// File: rtl/shift_add_multiplier.sv
// shift_add_multiplier: radix-2 sequential unsigned multiplier, one partial product per cycle, valid/ready handshakes
module shift_add_multiplier
    import mult_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_valid,
    output logic               start_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               result_valid,
    input  logic               result_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               busy
);
    localparam int CW = cnt_width(WIDTH);

    state_t                 state;
    state_t                 state_nx;
    logic [WIDTH-1:0]       mcand;
    logic [WIDTH-1:0]       acc_hi;
    logic [WIDTH-1:0]       acc_lo;
    logic [WIDTH-1:0]       addend;
    logic [WIDTH-1:0]       sum;
    logic                   cout;
    logic [CW-1:0]          cnt;
    logic                   last;
    logic [2*WIDTH-1:0]     step;

    assign addend = acc_lo[0] ? mcand : '0;
    assign last   = cnt == CW'(WIDTH - 1);
    // carry-out becomes the new MSB as the whole accumulator shifts right
    assign step   = {cout, sum, acc_lo[WIDTH-1:1]};

    carry_lookahead_adder #(.WIDTH(WIDTH)) u_add (
        .a   (acc_hi),
        .b   (addend),
        .cin (1'b0),
        .sum (sum),
        .cout(cout)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx     = state;
        state_nx     = (state == IDLE && start_valid)  ? BUSY :
                       (state == BUSY && last)         ? DONE :
                       (state == DONE && result_ready) ? IDLE : state;
        start_ready  = state == IDLE;
        result_valid = state == DONE;
        busy         = state != IDLE;
    end

    // product is a separate register so it survives the return to IDLE and the next load
    always_ff @(posedge clk) begin
        if (rst) begin
            mcand   <= '0;
            acc_hi  <= '0;
            acc_lo  <= '0;
            cnt     <= '0;
            product <= '0;
        end else if (state == IDLE && start_valid) begin
            mcand  <= a;
            acc_hi <= '0;
            acc_lo <= b;
            cnt    <= '0;
        end else if (state == BUSY) begin
            {acc_hi, acc_lo} <= step;
            cnt              <= cnt + CW'(1);
            if (last) product <= step;
        end
    end
endmodule

// File: tb/tb_shift_add_multiplier.sv
// tb_shift_add_multiplier: randomized and directed checks of the multiplier against plain a*b arithmetic
module tb_shift_add_multiplier;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_valid = 1'b0, start_ready, result_valid, result_ready = 1'b0, busy;
    logic [7:0]  a = '0, b = '0;
    logic [15:0] product;
    logic        sv2 = 1'b0, sr2, rv2, rr2 = 1'b1, bz2;
    logic [1:0]  a2 = '0, b2 = '0;
    logic [3:0]  p2;
    logic        sv16 = 1'b0, sr16, rv16, rr16 = 1'b1, bz16;
    logic [15:0] a16 = '0, b16 = '0;
    logic [31:0] p16;
    int          n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;

    shift_add_multiplier #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(start_ready),
        .a(a), .b(b), .result_valid(result_valid), .result_ready(result_ready),
        .product(product), .busy(busy)
    );
    shift_add_multiplier #(.WIDTH(2)) dut2 (
        .clk(clk), .rst(rst), .start_valid(sv2), .start_ready(sr2),
        .a(a2), .b(b2), .result_valid(rv2), .result_ready(rr2),
        .product(p2), .busy(bz2)
    );
    shift_add_multiplier #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .start_valid(sv16), .start_ready(sr16),
        .a(a16), .b(b16), .result_valid(rv16), .result_ready(rr16),
        .product(p16), .busy(bz16)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // full transaction on the WIDTH=8 instance, optionally stalling the sink for hold cycles
    task automatic do_op(input logic [7:0] x, input logic [7:0] y, input int hold, input string tag);
        int          n;
        logic [15:0] exp;
        exp          = 16'(x) * 16'(y);
        a            = x;
        b            = y;
        start_valid  = 1'b1;
        result_ready = (hold == 0);
        n = 0;
        while (!start_ready && n < 50) begin tick(); n++; end
        check({tag, "_start_ready"}, start_ready, 1);
        tick();
        start_valid = 1'b0;
        a = 8'($urandom);
        b = 8'($urandom);
        n = 0;
        while (!result_valid && n < 50) begin tick(); n++; end
        check({tag, "_latency"}, n, 8);
        check({tag, "_product"}, product, exp);
        for (int k = 0; k < hold; k++) begin
            start_valid = 1'b1;
            a = 8'($urandom);
            b = 8'($urandom);
            tick();
            check({tag, "_hold_valid"}, result_valid, 1);
            check({tag, "_hold_product"}, product, exp);
            check({tag, "_hold_start_ready"}, start_ready, 0);
        end
        start_valid  = 1'b0;
        result_ready = 1'b1;
        tick();
        check({tag, "_valid_drop"}, result_valid, 0);
        check({tag, "_idle_ready"}, start_ready, 1);
        check({tag, "_idle_busy"}, busy, 0);
        check({tag, "_product_kept"}, product, exp);
    endtask

    task automatic op2(input logic [1:0] x, input logic [1:0] y);
        int n;
        a2 = x; b2 = y; sv2 = 1'b1;
        n = 0;
        while (!sr2 && n < 20) begin tick(); n++; end
        tick();
        sv2 = 1'b0;
        n = 0;
        while (!rv2 && n < 20) begin tick(); n++; end
        check("w2_latency", n, 2);
        check("w2_product", p2, 4'(x) * 4'(y));
        tick();
    endtask

    task automatic op16(input logic [15:0] x, input logic [15:0] y);
        int n;
        a16 = x; b16 = y; sv16 = 1'b1;
        n = 0;
        while (!sr16 && n < 40) begin tick(); n++; end
        tick();
        sv16 = 1'b0;
        n = 0;
        while (!rv16 && n < 40) begin tick(); n++; end
        check("w16_latency", n, 16);
        check("w16_product", p16, 32'(x) * 32'(y));
        tick();
    endtask

    initial begin
        logic [15:0] q[$];
        int          issued, got, cyc, last_acc;
        repeat (2) tick();
        rst = 1'b0;
        check("rst_start_ready", start_ready, 1);
        check("rst_result_valid", result_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_product", product, 0);

        do_op(8'd13, 8'd11, 0, "t13x11");
        do_op(8'd255, 8'd255, 0, "t255x255");
        do_op(8'd0, 8'd200, 0, "t0x200");
        do_op(8'd200, 8'd0, 0, "t200x0");
        do_op(8'd1, 8'd255, 0, "t1x255");
        do_op(8'd128, 8'd2, 0, "t128x2");
        do_op(8'd77, 8'd201, 5, "backpressure");

        a = 8'd200; b = 8'd200; start_valid = 1'b1; result_ready = 1'b1;
        tick();
        start_valid = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_start_ready", start_ready, 1);
        check("abort_result_valid", result_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_product", product, 0);
        do_op(8'd7, 8'd9, 0, "t7x9");

        for (int k = 0; k < 10; k++) do_op(8'($urandom), 8'($urandom), k % 3, "rand");

        issued = 0; got = 0; cyc = 0; last_acc = -1;
        result_ready = 1'b1;
        while (got < 100 && cyc < 2000) begin
            if (result_valid && result_ready) begin
                check("b2b_product", product, q.size() ? q.pop_front() : 16'hxxxx);
                got++;
            end
            a = 8'($urandom);
            b = 8'($urandom);
            start_valid = issued < 100;
            if (start_ready && start_valid) begin
                q.push_back(16'(a) * 16'(b));
                if (last_acc >= 0) check("b2b_interval", cyc - last_acc, 10);
                last_acc = cyc;
                issued++;
            end
            tick();
            cyc++;
        end
        start_valid = 1'b0;
        check("b2b_results", got, 100);

        op2(2'd3, 2'd3);
        op2(2'd2, 2'd3);
        op16(16'hFFFF, 16'hFFFF);
        op16(16'($urandom), 16'($urandom));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
